// File: rtl/clocking_in.sv
// AXI-Stream receive buffer: assembles FFT_SIZE complex beats into a shadow frame and launches
// it to a stable parallel output. Define CLOCKING_IN_TLAST_CHECK_EN to enable tlast framing checks.
module clocking_in #(
  parameter int unsigned FFT_SIZE     = 8,
  parameter int unsigned FFT_SIZE_LOG = 3,
  parameter int unsigned WIDTH        = 18,
  parameter int unsigned DECIMAL      = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        dma_tvalid,
  output logic                        dma_tready,
  input  logic                        dma_tlast,
  input  logic signed [WIDTH-1:0]     data_in_R,
  input  logic signed [WIDTH-1:0]     data_in_I,
  input  logic                        fft_ready,
  output logic                        start,
  output logic [FFT_SIZE*WIDTH-1:0]   data_out_R,
  output logic [FFT_SIZE*WIDTH-1:0]   data_out_I,
  output logic                        frame_err
);

  localparam logic [FFT_SIZE_LOG-1:0] LastIdx = FFT_SIZE_LOG'(FFT_SIZE - 1);

  typedef enum logic [0:0] {StFill, StFull} state_e;

  state_e                    state_q, state_d;
  logic [FFT_SIZE_LOG-1:0]   idx_q, idx_d;
  logic                      tready_q;
  logic                      start_q;
  logic                      err_q, err_d;
  logic [FFT_SIZE*WIDTH-1:0] shadow_r_q, shadow_i_q;
  logic [FFT_SIZE*WIDTH-1:0] out_r_q, out_i_q;
  logic                      accept;
  logic                      launch;
  logic                      clear_tail;

  assign accept = dma_tvalid && tready_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    launch     = 1'b0;
    clear_tail = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          if (idx_q == LastIdx) begin
            state_d = StFull;
            idx_d   = '0;
`ifdef CLOCKING_IN_TLAST_CHECK_EN
            err_d   = !dma_tlast;
`endif
          end
`ifdef CLOCKING_IN_TLAST_CHECK_EN
          // Short packet: close the frame now and zero-pad the unused slots.
          else if (dma_tlast) begin
            state_d    = StFull;
            idx_d      = '0;
            clear_tail = 1'b1;
            err_d      = 1'b1;
          end
`endif
          else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StFull: begin
        if (fft_ready) begin
          launch  = 1'b1;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StFill;
      idx_q      <= '0;
      tready_q   <= 1'b0;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
      shadow_r_q <= '0;
      shadow_i_q <= '0;
      out_r_q    <= '0;
      out_i_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      // Ready is registered from the next state so it drops on the edge that fills the frame.
      tready_q <= (state_d == StFill);
      start_q  <= launch;
      err_q    <= err_d;
      if (accept) begin
        shadow_r_q[idx_q*WIDTH +: WIDTH] <= data_in_R;
        shadow_i_q[idx_q*WIDTH +: WIDTH] <= data_in_I;
      end
      if (clear_tail) begin
        for (int k = 0; k < int'(FFT_SIZE); k++) begin
          if (k > int'(idx_q)) begin
            shadow_r_q[k*WIDTH +: WIDTH] <= '0;
            shadow_i_q[k*WIDTH +: WIDTH] <= '0;
          end
        end
      end
      if (launch) begin
        out_r_q <= shadow_r_q;
        out_i_q <= shadow_i_q;
      end
    end
  end

  assign dma_tready = tready_q;
  assign start      = start_q;
  assign data_out_R = out_r_q;
  assign data_out_I = out_i_q;

`ifdef CLOCKING_IN_TLAST_CHECK_EN
  assign frame_err = err_q;
  logic unused_cfg;
  assign unused_cfg = (DECIMAL < WIDTH);
`else
  assign frame_err = 1'b0;
  logic unused_cfg;
  assign unused_cfg = (DECIMAL < WIDTH) ^ dma_tlast ^ err_q;
`endif

endmodule

// File: tb/tb_clocking_in.sv
// Self-checking bench for clocking_in: table-driven frames, a scoreboard of expected launched
// frames, and directed sequences for reset, back-pressure, overlap and tlast framing.
module tb_clocking_in;

  localparam int N  = 8;
  localparam int W  = 18;
  localparam int FW = N * W;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                dma_tvalid = 1'b0;
  logic                dma_tlast = 1'b0;
  logic                fft_ready = 1'b0;
  logic signed [W-1:0] data_in_R = '0;
  logic signed [W-1:0] data_in_I = '0;
  logic                dma_tready;
  logic                start;
  logic                frame_err;
  logic [FW-1:0]       data_out_R;
  logic [FW-1:0]       data_out_I;

  always #5 clk = ~clk;

  clocking_in #(
    .FFT_SIZE    (N),
    .FFT_SIZE_LOG(3),
    .WIDTH       (W),
    .DECIMAL     (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dma_tvalid(dma_tvalid),
    .dma_tready(dma_tready),
    .dma_tlast (dma_tlast),
    .data_in_R (data_in_R),
    .data_in_I (data_in_I),
    .fft_ready (fft_ready),
    .start     (start),
    .data_out_R(data_out_R),
    .data_out_I(data_out_I),
    .frame_err (frame_err)
  );

  typedef struct {
    logic [FW-1:0] r;
    logic [FW-1:0] i;
  } frame_t;

  typedef struct {
    int r;
    int i;
    bit last;
    int gap;
    int exp_r;
    int exp_i;
  } vec_t;

  vec_t   tbl[N];
  frame_t sb[$];
  frame_t held;
  int     total = 0;
  int     bad = 0;
  int     starts = 0;
  int     errs = 0;
  bit     prev_start = 1'b0;

  function automatic void chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // Output monitor: every launch must match the scoreboard, otherwise the outputs must hold.
  always begin
    frame_t e;
    @(negedge clk);
    #1;
    if (!rst_n) begin
      held.r     = '0;
      held.i     = '0;
      prev_start = 1'b0;
    end else begin
      if (start) begin
        starts++;
        if (prev_start) begin
          total++;
          bad++;
          $display("FAIL start_consecutive: got 2 cycles want 1");
        end
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_start: got start want none");
        end else begin
          e = sb.pop_front();
          chk("launch_R", data_out_R, e.r);
          chk("launch_I", data_out_I, e.i);
          held = e;
        end
      end else begin
        chk("hold_R", data_out_R, held.r);
        chk("hold_I", data_out_I, held.i);
      end
      prev_start = start;
`ifdef CLOCKING_IN_TLAST_CHECK_EN
      if (frame_err) errs++;
`else
      chk("frame_err_tied", {{(FW-1){1'b0}}, frame_err}, '0);
`endif
    end
  end

  task automatic idle(input int n);
    dma_tvalid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_beat(input int r, input int i, input bit last);
    int guard = 0;
    dma_tvalid = 1'b1;
    data_in_R  = W'(r);
    data_in_I  = W'(i);
    dma_tlast  = last;
    while (!dma_tready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!dma_tready) begin
      total++;
      bad++;
      $display("FAIL beat_accept_timeout: got tready=0 want 1");
    end
    @(negedge clk);
    dma_tvalid = 1'b0;
    dma_tlast  = 1'b0;
  endtask

  task automatic run_frame(input int n, input bit push);
    frame_t f;
    f.r = '0;
    f.i = '0;
    for (int k = 0; k < n; k++) begin
      if (tbl[k].gap > 0) idle(tbl[k].gap);
      f.r[k*W +: W] = W'(tbl[k].exp_r);
      f.i[k*W +: W] = W'(tbl[k].exp_i);
      send_beat(tbl[k].r, tbl[k].i, tbl[k].last);
    end
    if (push) sb.push_back(f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int s0;
    int e0;
    int v;

    // Reset
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tready", {{(FW-1){1'b0}}, dma_tready}, '0);
      chk("rst_start", {{(FW-1){1'b0}}, start}, '0);
      chk("rst_out_R", data_out_R, '0);
      chk("rst_out_I", data_out_I, '0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready_after_release", {{(FW-1){1'b0}}, dma_tready}, 1);

    // Continuous stream R=k, I=-k
    fft_ready = 1'b1;
    for (int k = 0; k < N; k++) tbl[k] = '{k, -k, (k == N - 1), 0, k, -k};
    run_frame(N, 1'b1);
    chk("full_tready_low", {{(FW-1){1'b0}}, dma_tready}, 0);
    chk("full_no_start", {{(FW-1){1'b0}}, start}, 0);
    @(negedge clk);
    chk("launch_start", {{(FW-1){1'b0}}, start}, 1);
    chk("launch_tready", {{(FW-1){1'b0}}, dma_tready}, 1);

    // Back-pressure: fft_ready low for 5 cycles in FULL
    fft_ready = 1'b0;
    idle(2);
    for (int k = 0; k < N; k++) tbl[k] = '{100 + k, -(200 + k), (k == N - 1), 0, 100 + k, -(200 + k)};
    run_frame(N, 1'b1);
    for (int c = 0; c < 6; c++) begin
      chk("bp_tready", {{(FW-1){1'b0}}, dma_tready}, 0);
      chk("bp_start", {{(FW-1){1'b0}}, start}, 0);
      if (c < 5) @(negedge clk);
    end
    fft_ready = 1'b1;
    @(negedge clk);
    chk("bp_launch_start", {{(FW-1){1'b0}}, start}, 1);
    chk("bp_launch_tready", {{(FW-1){1'b0}}, dma_tready}, 1);

    // Overlap: frame A back-to-back, then frame B with random gaps
    idle(2);
    s0 = starts;
    for (int k = 0; k < N; k++) begin
      v = int'($urandom_range(0, (1 << W) - 1));
      tbl[k] = '{v, ~v, (k == N - 1), 0, v, ~v};
    end
    run_frame(N, 1'b1);
    for (int k = 0; k < N; k++) begin
      v = int'($urandom_range(0, (1 << W) - 1));
      tbl[k] = '{v, v ^ 12345, (k == N - 1), int'($urandom_range(0, 3)), v, v ^ 12345};
    end
    run_frame(N, 1'b1);
    idle(3);
    chk("overlap_starts", FW'(starts - s0), 2);

    // Mid-frame reset discards the partial frame
    s0 = starts;
    for (int k = 0; k < 5; k++) tbl[k] = '{500 + k, -(500 + k), 1'b0, 0, 500 + k, -(500 + k)};
    run_frame(5, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) tbl[k] = '{600 + k, -(600 + k), (k == N - 1), 0, 600 + k, -(600 + k)};
    run_frame(N, 1'b1);
    idle(3);
    chk("reset_starts", FW'(starts - s0), 1);

`ifdef CLOCKING_IN_TLAST_CHECK_EN
    // Early tlast on beat 3: zero-padded frame and one error pulse
    e0 = errs;
    s0 = starts;
    for (int k = 0; k < 4; k++) tbl[k] = '{k + 1, -(k + 1), (k == 3), 0, k + 1, -(k + 1)};
    run_frame(4, 1'b1);
    chk("early_err_now", {{(FW-1){1'b0}}, frame_err}, 1);
    idle(3);
    chk("early_err_count", FW'(errs - e0), 1);
    chk("early_starts", FW'(starts - s0), 1);
    // Missing tlast: normal frame, one error pulse
    e0 = errs;
    for (int k = 0; k < N; k++) tbl[k] = '{700 + k, -(700 + k), 1'b0, 0, 700 + k, -(700 + k)};
    run_frame(N, 1'b1);
    idle(3);
    chk("missing_err_count", FW'(errs - e0), 1);
`else
    // tlast ignored: an early tlast does not shorten the frame
    e0 = errs;
    s0 = starts;
    for (int k = 0; k < N; k++) tbl[k] = '{800 + k, -(800 + k), (k == 3), 0, 800 + k, -(800 + k)};
    run_frame(N, 1'b1);
    idle(3);
    chk("tlast_ignored_starts", FW'(starts - s0), 1);
    chk("tlast_ignored_errs", FW'(errs - e0), 0);
`endif

    idle(3);
    chk("sb_empty", FW'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
